demux_16_reg: RTL and testbench
===============================

Name: demux_16_reg

Overview:
- Registered 1-to-2, 16-bit demultiplexer: the write-side counterpart of the datapath 2-to-1 mux.
- Takes one 16-bit source stream and steers each word, per a select bit, into one of two destination holding registers (A or B).
- Each destination has a one-entry buffer with valid/ready handshake. Used to route ALU/memory results toward two consumers without a combinational path from producer to consumer.
- Each destination also keeps a wrap-around transfer counter for debug/perf.

Parameters:
WIDTH, 16, data width of input and both outputs
CNT_W, 8, width of each per-destination transfer counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_data  input  WIDTH  source word
in_sel  input  1  destination select: 0 -> A, 1 -> B
in_valid  input  1  source offers in_data/in_sel this cycle
in_ready  output  1  block accepts the offered word this cycle
a_data  output  WIDTH  destination A word
a_valid  output  1  a_data holds an undelivered word
a_ready  input  1  consumer A takes a_data this cycle
b_data  output  WIDTH  destination B word
b_valid  output  1  b_data holds an undelivered word
b_ready  input  1  consumer B takes b_data this cycle
a_count  output  CNT_W  number of words delivered to A, modulo 2^CNT_W
b_count  output  CNT_W  number of words delivered to B, modulo 2^CNT_W

Behaviour:
- Reset: clk and rst only; rst sampled on rising edge. Next edge clears a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0, b_count=0. rst overrides all activity, including words in flight or a simultaneous accept; buffered undelivered words are discarded. in_ready is 0 while rst is high.
- Slot state per destination: EMPTY (valid=0) or FULL (valid=1). Two independent 1-bit state machines.
  - EMPTY -> FULL on accept into that slot.
  - FULL -> EMPTY on drain (valid && ready) without a same-cycle accept.
  - FULL -> FULL on drain plus accept: data replaced, valid stays 1.
- in_ready (combinational, depends only on in_sel, the slot state and that slot's ready):
  - in_sel=0: in_ready = !a_valid || a_ready.
  - in_sel=1: in_ready = !b_valid || b_ready.
  - The unselected slot never affects in_ready.
- Accept = in_valid && in_ready. On accept, the selected slot loads in_data at the edge and its valid is 1 the next cycle. Latency is 1 cycle; the unselected slot is untouched.
- Drain + accept same slot, same cycle: the old word is delivered, the new word is loaded, and valid stays 1. No bubble; full throughput of 1 word/cycle per slot.
- Accept into one slot while the other drains: both happen independently.
- Output stability: while x_valid=1 and x_ready=0, x_data and x_valid hold.
- in_valid with in_ready=0: nothing is captured. The source must hold in_data/in_sel stable until accepted; the block does not check this.
- x_data when x_valid=0 holds the last loaded value (0 after reset); consumers ignore it.
- Counters:
  - x_count increments by 1 on each drain (x_valid && x_ready).
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - Counters are never cleared except by rst.
- No combinational path from in_data to a_data/b_data. in_ready is the only output combinationally dependent on inputs.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then idle -> a_valid=b_valid=0, a_data=b_data=0, counts=0. With in_valid=1 during rst -> nothing captured, in_ready=0.
- Single steer: in_data=16'h1234, in_sel=0, in_valid=1 for 1 cycle, a_ready=1 -> next cycle a_valid=1, a_data=16'h1234, b_valid=0. One cycle later a_valid=0, a_count=1.
- Backpressure: a_ready=0, send 16'hAAAA to A, then offer 16'hBBBB to A -> in_ready=0, a_data stays 16'hAAAA. Offer 16'hCCCC with in_sel=1 -> accepted, b_data=16'hCCCC. Raise a_ready -> 16'hBBBB accepted in the same cycle 16'hAAAA drains, then a_data=16'hBBBB.
- Streaming: a_ready=1, 10 back-to-back words 0..9 to A -> in_ready stays 1, a_data follows the input one cycle later, a_count=10, no gaps.
- Counter wrap: 256 deliveries to B with CNT_W=8 -> b_count returns to 0. The 257th delivery -> b_count=1. a_count is unchanged.
- Reset mid-operation: A FULL with 16'h5555, B FULL with 16'h6666, rst=1 together with an accept -> next cycle both valids=0, data=0, counts=0, and the offered word is lost.

Source files
------------

// File: rtl/demux_16_reg.sv
// Registered 1-to-2 demultiplexer: steers each source word into one of two
// single-entry holding slots (A or B), each with its own delivery counter.
module demux_16_reg #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  // Handshake: a word moves across an interface on a rising edge where both
  // valid and ready are high; a producer holding valid keeps its data stable
  // until that edge, and ready never waits on the same side's valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t a_state_q, a_state_d;
  slot_state_t b_state_q, b_state_d;

  logic [WIDTH-1:0] a_data_q, b_data_q;
  logic [CNT_W-1:0] a_count_q, b_count_q;

  logic a_slot_ready, b_slot_ready;
  logic accept_a, accept_b;
  logic drain_a, drain_b;

  assign a_valid = (a_state_q == FULL);
  assign b_valid = (b_state_q == FULL);
  assign a_data  = a_data_q;
  assign b_data  = b_data_q;
  assign a_count = a_count_q;
  assign b_count = b_count_q;

  // A slot can take a word if it is empty or is being emptied this cycle.
  assign a_slot_ready = !a_valid || a_ready;
  assign b_slot_ready = !b_valid || b_ready;
  assign in_ready     = !rst && (in_sel ? b_slot_ready : a_slot_ready);

  assign accept_a = in_valid && in_ready && !in_sel;
  assign accept_b = in_valid && in_ready &&  in_sel;
  assign drain_a  = a_valid && a_ready;
  assign drain_b  = b_valid && b_ready;

  always_comb begin
    a_state_d = a_state_q;
    b_state_d = b_state_q;
    if (accept_a) begin
      a_state_d = FULL;
    end else if (drain_a) begin
      a_state_d = EMPTY;
    end
    if (accept_b) begin
      b_state_d = FULL;
    end else if (drain_b) begin
      b_state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_state_q <= EMPTY;
      b_state_q <= EMPTY;
      a_data_q  <= '0;
      b_data_q  <= '0;
      a_count_q <= '0;
      b_count_q <= '0;
    end else begin
      a_state_q <= a_state_d;
      b_state_q <= b_state_d;
      if (accept_a) a_data_q <= in_data;
      if (accept_b) b_data_q <= in_data;
      // Counters wrap silently at 2^CNT_W.
      if (drain_a) a_count_q <= a_count_q + 1'b1;
      if (drain_b) b_count_q <= b_count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_16_reg.sv
// Bench for demux_16_reg: directed vectors with literal checks, plus a
// per-cycle comparison against a slot-array model of the two destinations.
module tb_demux_16_reg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  int n_cmp;
  int n_bad;
  logic chk_en;

  demux_16_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: index 0 is destination A, index 1 is destination B
  logic             m_valid[2];
  logic [WIDTH-1:0] m_data[2];
  int               m_cnt[2];

  function automatic logic m_in_ready();
    logic [1:0] rdy;
    rdy = {b_ready, a_ready};
    if (rst) return 1'b0;
    return !m_valid[in_sel] || rdy[in_sel];
  endfunction

  always @(posedge clk) begin
    logic       take;
    logic [1:0] rdy;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_valid[d] = 1'b0;
        m_data[d]  = '0;
        m_cnt[d]   = 0;
      end
    end else begin
      take = in_valid && m_in_ready();
      rdy  = {b_ready, a_ready};
      for (int d = 0; d < 2; d++) begin
        if (m_valid[d] && rdy[d]) begin
          m_cnt[d]   = m_cnt[d] + 1;
          m_valid[d] = 1'b0;
        end
      end
      if (take) begin
        m_data[in_sel]  = in_data;
        m_valid[in_sel] = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.in_ready", 32'(in_ready), 32'(m_in_ready()));
      chk("m.a_valid",  32'(a_valid),  32'(m_valid[0]));
      chk("m.b_valid",  32'(b_valid),  32'(m_valid[1]));
      chk("m.a_data",   32'(a_data),   32'(m_data[0]));
      chk("m.b_data",   32'(b_data),   32'(m_data[1]));
      chk("m.a_count",  32'(a_count),  32'(m_cnt[0] % (1 << CNT_W)));
      chk("m.b_count",  32'(b_count),  32'(m_cnt[1] % (1 << CNT_W)));
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [WIDTH-1:0] d, input logic s);
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 1'b0;
    rst = 1'b1; in_data = 16'hFFFF; in_sel = 1'b0; in_valid = 1'b1;
    a_ready = 1'b0; b_ready = 1'b0;

    // reset with an offered word
    cyc();
    chk_en = 1'b1;
    settle();
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    settle();
    chk("rst.a_valid", 32'(a_valid), 32'h0);
    chk("rst.b_valid", 32'(b_valid), 32'h0);
    chk("rst.a_data",  32'(a_data),  32'h0);
    chk("rst.b_data",  32'(b_data),  32'h0);
    chk("rst.a_count", 32'(a_count), 32'h0);
    chk("rst.b_count", 32'(b_count), 32'h0);

    // single steer to A
    a_ready = 1'b1;
    offer(16'h1234, 1'b0);
    settle();
    chk("one.in_ready", 32'(in_ready), 32'h1);
    cyc();
    in_valid = 1'b0;
    settle();
    chk("one.a_valid", 32'(a_valid), 32'h1);
    chk("one.a_data",  32'(a_data),  32'h1234);
    chk("one.b_valid", 32'(b_valid), 32'h0);
    cyc();
    settle();
    chk("one.a_drained", 32'(a_valid), 32'h0);
    chk("one.a_count",   32'(a_count), 32'h1);

    // backpressure on A, B independent
    a_ready = 1'b0;
    offer(16'hAAAA, 1'b0);
    cyc();
    offer(16'hBBBB, 1'b0);
    settle();
    chk("bp.in_ready_a_full", 32'(in_ready), 32'h0);
    cyc();
    settle();
    chk("bp.a_hold", 32'(a_data), 32'hAAAA);
    offer(16'hCCCC, 1'b1);
    settle();
    chk("bp.in_ready_b", 32'(in_ready), 32'h1);
    cyc();
    settle();
    chk("bp.b_valid", 32'(b_valid), 32'h1);
    chk("bp.b_data",  32'(b_data),  32'hCCCC);
    chk("bp.a_still", 32'(a_data),  32'hAAAA);
    offer(16'hBBBB, 1'b0);
    a_ready = 1'b1;
    settle();
    chk("bp.in_ready_drain", 32'(in_ready), 32'h1);
    cyc();
    in_valid = 1'b0; a_ready = 1'b0;
    settle();
    chk("bp.a_valid_swap", 32'(a_valid), 32'h1);
    chk("bp.a_data_swap",  32'(a_data),  32'hBBBB);
    chk("bp.a_count_swap", 32'(a_count), 32'h2);
    a_ready = 1'b1; b_ready = 1'b1;
    cyc();
    a_ready = 1'b0; b_ready = 1'b0;
    settle();
    chk("bp.a_empty", 32'(a_valid), 32'h0);
    chk("bp.b_empty", 32'(b_valid), 32'h0);
    chk("bp.a_count", 32'(a_count), 32'h3);
    chk("bp.b_count", 32'(b_count), 32'h1);

    // streaming 10 words to A
    a_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(16'(i), 1'b0);
      settle();
      chk("stream.in_ready", 32'(in_ready), 32'h1);
      cyc();
      settle();
      chk("stream.a_valid", 32'(a_valid), 32'h1);
      chk("stream.a_data",  32'(a_data),  32'(i));
    end
    in_valid = 1'b0;
    cyc();
    settle();
    chk("stream.a_count", 32'(a_count), 32'd13);
    chk("stream.a_empty", 32'(a_valid), 32'h0);

    // counter wrap on B: 1 already delivered, 255 more reaches 256 -> 0
    a_ready = 1'b0; b_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      offer(16'(16'h100 + i), 1'b1);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    settle();
    chk("wrap.b_count0", 32'(b_count), 32'h0);
    chk("wrap.a_count",  32'(a_count), 32'd13);
    offer(16'h0ABC, 1'b1);
    cyc();
    in_valid = 1'b0;
    cyc();
    settle();
    chk("wrap.b_count1", 32'(b_count), 32'h1);
    chk("wrap.b_data",   32'(b_data),  32'h0ABC);

    // reset mid-operation with both slots full and an accept offered
    b_ready = 1'b0;
    offer(16'h5555, 1'b0);
    cyc();
    offer(16'h6666, 1'b1);
    cyc();
    in_valid = 1'b0;
    settle();
    chk("mid.a_valid", 32'(a_valid), 32'h1);
    chk("mid.b_valid", 32'(b_valid), 32'h1);
    rst = 1'b1; a_ready = 1'b1;
    offer(16'h7777, 1'b0);
    settle();
    chk("mid.in_ready_rst", 32'(in_ready), 32'h0);
    cyc();
    rst = 1'b0; in_valid = 1'b0; a_ready = 1'b0;
    settle();
    chk("mid.a_valid0", 32'(a_valid), 32'h0);
    chk("mid.b_valid0", 32'(b_valid), 32'h0);
    chk("mid.a_data0",  32'(a_data),  32'h0);
    chk("mid.b_data0",  32'(b_data),  32'h0);
    chk("mid.a_count0", 32'(a_count), 32'h0);
    chk("mid.b_count0", 32'(b_count), 32'h0);
    cyc();
    cyc();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
